// File: rtl/conf_int_mul_pkg.sv
// Shared types and helpers for the sequential accurate/approximate multiplier.
//   state_t    : FSM states of the multiplier top.
//   MODE_ACC   : mode value selecting the exact two-pass product.
//   MODE_APX   : mode value selecting the truncated one-pass product.
//   calc_bl()  : width of the unsigned low slice of operand b.
package conf_int_mul_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HI        = 3'd1,
    LO        = 3'd2,
    DONE_CALC = 3'd3,
    HOLD      = 3'd4
  } state_t;

  localparam logic MODE_ACC = 1'b0;
  localparam logic MODE_APX = 1'b1;

  // b is split into a signed high slice and an unsigned low slice of
  // floor(b_w/2) bits, so the high slice always carries the sign bit.
  function automatic int calc_bl(input int b_w);
    return b_w / 2;
  endfunction

endpackage

// File: rtl/sat_shift.sv
// Combinational output stage: arithmetic right shift of the full-width
// product followed by saturation to the output width.
//   acc      : in,  FW-bit signed full product.
//   p_next   : out, OUT_W-bit signed shifted and saturated value.
//   sat_next : out, 1 when the shifted value did not fit in OUT_W bits.
module sat_shift #(
  parameter int FW        = 37,
  parameter int OUT_W     = 32,
  parameter int OUT_SHIFT = 8
) (
  input  logic [FW-1:0]    acc,
  output logic [OUT_W-1:0] p_next,
  output logic             sat_next
);

  logic signed [FW-1:0] shifted;

  // Arithmetic shift gives floor rounding for negative products.
  assign shifted = $signed(acc) >>> OUT_SHIFT;

  generate
    if (OUT_W < FW) begin : g_sat
      // The value fits in OUT_W bits only if every bit from the OUT_W sign
      // position upward is a copy of the sign bit.
      logic [FW-OUT_W:0] top_bits;
      logic              pos_ovf;
      logic              neg_ovf;

      always_comb begin
        top_bits = shifted[FW-1:OUT_W-1];
        pos_ovf  = !shifted[FW-1] && (top_bits != '0);
        neg_ovf  = shifted[FW-1] && (top_bits != '1);
        sat_next = pos_ovf || neg_ovf;
        if (pos_ovf) begin
          p_next = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (neg_ovf) begin
          p_next = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
          p_next = shifted[OUT_W-1:0];
        end
      end
    end else begin : g_wide
      // Output is at least as wide as the product, so overflow is impossible.
      always_comb begin
        p_next   = OUT_W'(shifted);
        sat_next = 1'b0;
      end
    end
  endgenerate

endmodule

// File: rtl/conf_int_mul_seq_apx.sv
// Handshaked signed multiplier with an exact two-pass mode and a truncated
// one-pass approximate mode. The product is shifted, saturated and counted.
//   clk, rstN            : clock and asynchronous active-low reset.
//   in_valid/in_ready    : operand handshake; a, b, mode taken on accept.
//   out_valid/out_ready  : result handshake; p and sat held until taken.
//   busy                 : high whenever the FSM is not idle.
//   acc_cnt, apx_cnt     : completed operations per mode, wrapping.
module conf_int_mul_seq_apx
  import conf_int_mul_pkg::*;
#(
  parameter int DATA_W    = 24,
  parameter int B_W       = 13,
  parameter int OUT_W     = 32,
  parameter int TRUNC     = 8,
  parameter int OUT_SHIFT = 8,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [B_W-1:0]    b,
  input  logic              mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  p,
  output logic              sat,
  output logic              busy,
  output logic [CNT_W-1:0]  acc_cnt,
  output logic [CNT_W-1:0]  apx_cnt
);

  localparam int FW = DATA_W + B_W;
  localparam int BL = calc_bl(B_W);
  localparam int HW = B_W - BL;

  localparam logic [DATA_W-1:0] TRUNC_MASK = {DATA_W{1'b1}} << TRUNC;

  state_t state;
  state_t state_next;

  logic [DATA_W-1:0] a_reg;
  logic [B_W-1:0]    b_reg;
  logic              mode_reg;
  logic [FW-1:0]     acc;
  logic [OUT_W-1:0]  p_reg;
  logic              sat_reg;
  logic              out_valid_reg;
  logic [CNT_W-1:0]  acc_cnt_reg;
  logic [CNT_W-1:0]  apx_cnt_reg;

  logic [FW-1:0]     a_ext;
  logic [FW-1:0]     b_hi_ext;
  logic [FW-1:0]     b_lo_ext;
  logic [FW-1:0]     hi_prod;
  logic [FW-1:0]     lo_prod;
  logic [OUT_W-1:0]  p_next;
  logic              sat_next;
  logic              accept;

  // Operands are widened to the full product width so a plain FW-bit
  // multiply is exact: a and the high slice of b are sign extended, the
  // low slice of b is zero extended.
  assign a_ext    = {{B_W{a_reg[DATA_W-1]}}, a_reg};
  assign b_hi_ext = {{(FW-HW){b_reg[B_W-1]}}, b_reg[B_W-1:BL]};
  assign b_lo_ext = {{(FW-BL){1'b0}}, b_reg[BL-1:0]};
  assign hi_prod  = a_ext * b_hi_ext;
  assign lo_prod  = a_ext * b_lo_ext;

  assign accept = (state == IDLE) && in_valid;

  sat_shift #(
    .FW        (FW),
    .OUT_W     (OUT_W),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_sat_shift (
    .acc      (acc),
    .p_next   (p_next),
    .sat_next (sat_next)
  );

  // State register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the state-derived handshake outputs.
  // Approximate operations skip the low-slice pass entirely.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_next = HI;
        end
      end
      HI: begin
        state_next = (mode_reg == MODE_APX) ? DONE_CALC : LO;
      end
      LO: begin
        state_next = DONE_CALC;
      end
      DONE_CALC: begin
        state_next = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture and partial-product accumulation. In approximate mode
  // the low TRUNC bits of a are dropped at capture time.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      a_reg    <= '0;
      b_reg    <= '0;
      mode_reg <= MODE_ACC;
      acc      <= '0;
    end else begin
      if (accept) begin
        a_reg    <= (mode == MODE_APX) ? (a & TRUNC_MASK) : a;
        b_reg    <= b;
        mode_reg <= mode;
      end
      if (state == HI) begin
        acc <= hi_prod << BL;
      end else if (state == LO) begin
        acc <= acc + lo_prod;
      end
    end
  end

  // Result register, valid flag and per-mode counters. The result is
  // loaded once in DONE_CALC and then held through HOLD.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      p_reg         <= '0;
      sat_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      acc_cnt_reg   <= '0;
      apx_cnt_reg   <= '0;
    end else begin
      if (state == DONE_CALC) begin
        p_reg         <= p_next;
        sat_reg       <= sat_next;
        out_valid_reg <= 1'b1;
        if (mode_reg == MODE_APX) begin
          apx_cnt_reg <= apx_cnt_reg + CNT_W'(1);
        end else begin
          acc_cnt_reg <= acc_cnt_reg + CNT_W'(1);
        end
      end else if ((state == HOLD) && out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign p         = p_reg;
  assign sat       = sat_reg;
  assign out_valid = out_valid_reg;
  assign acc_cnt   = acc_cnt_reg;
  assign apx_cnt   = apx_cnt_reg;

endmodule

// File: tb/tb_conf_int_mul_seq_apx.sv
// Directed testbench for conf_int_mul_seq_apx. Three instances share the
// input stimulus: default parameters, OUT_W = 16, and OUT_SHIFT = 0.
// Each check looks at the instance selected by 'sel'.
module tb_conf_int_mul_seq_apx;

  typedef struct {
    int          sel;
    logic        mode;
    int          a;
    int          b;
    longint      exp_p;
    logic        exp_sat;
    int          exp_lat;
  } vec_t;

  logic        clk;
  logic        rstN;
  logic        in_valid;
  logic [23:0] a;
  logic [12:0] b;
  logic        mode;
  logic        out_ready;

  logic        in_ready_0, in_ready_1, in_ready_2;
  logic        out_valid_0, out_valid_1, out_valid_2;
  logic [31:0] p_0;
  logic [15:0] p_1;
  logic [31:0] p_2;
  logic        sat_0, sat_1, sat_2;
  logic        busy_0, busy_1, busy_2;
  logic [15:0] acc_cnt_0, acc_cnt_1, acc_cnt_2;
  logic [15:0] apx_cnt_0, apx_cnt_1, apx_cnt_2;

  int          sel;
  longint      cur_p;
  logic        cur_sat;
  logic        cur_ov;
  logic        cur_ready;
  logic        cur_busy;
  logic [15:0] cur_acc;
  logic [15:0] cur_apx;

  int          tests;
  int          fails;
  int          exp_acc;
  int          exp_apx;
  int          lat;
  vec_t        vecs[11];

  conf_int_mul_seq_apx u_def (
    .clk(clk), .rstN(rstN), .in_valid(in_valid), .in_ready(in_ready_0),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid_0), .out_ready(out_ready),
    .p(p_0), .sat(sat_0), .busy(busy_0), .acc_cnt(acc_cnt_0), .apx_cnt(apx_cnt_0)
  );

  conf_int_mul_seq_apx #(.OUT_W(16)) u_w16 (
    .clk(clk), .rstN(rstN), .in_valid(in_valid), .in_ready(in_ready_1),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid_1), .out_ready(out_ready),
    .p(p_1), .sat(sat_1), .busy(busy_1), .acc_cnt(acc_cnt_1), .apx_cnt(apx_cnt_1)
  );

  conf_int_mul_seq_apx #(.OUT_SHIFT(0)) u_s0 (
    .clk(clk), .rstN(rstN), .in_valid(in_valid), .in_ready(in_ready_2),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid_2), .out_ready(out_ready),
    .p(p_2), .sat(sat_2), .busy(busy_2), .acc_cnt(acc_cnt_2), .apx_cnt(apx_cnt_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs of the instance currently under test, p sign-extended.
  always_comb begin
    cur_p     = longint'($signed(p_0));
    cur_sat   = sat_0;
    cur_ov    = out_valid_0;
    cur_ready = in_ready_0;
    cur_busy  = busy_0;
    cur_acc   = acc_cnt_0;
    cur_apx   = apx_cnt_0;
    if (sel == 1) begin
      cur_p     = longint'($signed(p_1));
      cur_sat   = sat_1;
      cur_ov    = out_valid_1;
      cur_ready = in_ready_1;
      cur_busy  = busy_1;
      cur_acc   = acc_cnt_1;
      cur_apx   = apx_cnt_1;
    end else if (sel == 2) begin
      cur_p     = longint'($signed(p_2));
      cur_sat   = sat_2;
      cur_ov    = out_valid_2;
      cur_ready = in_ready_2;
      cur_busy  = busy_2;
      cur_acc   = acc_cnt_2;
      cur_apx   = apx_cnt_2;
    end
  end

  task automatic checkOutput(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Presents one operand set for a single accepting edge, then counts edges
  // (accept edge = 1) until out_valid rises, bounded by a cycle budget.
  task automatic applyStimulus(input logic m, input int av, input int bv, output int latency);
    @(negedge clk);
    a        = 24'(av);
    b        = 13'(bv);
    mode     = m;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = 24'h5a5a5a;
    b        = 13'h0aaa;
    mode     = ~m;
    latency  = 1;
    while (!cur_ov && latency < 20) begin
      @(posedge clk);
      #1;
      latency++;
    end
  endtask

  task automatic set_vec(input int i, input int s, input logic m, input int av,
                         input int bv, input longint ep, input logic es, input int el);
    vecs[i].sel     = s;
    vecs[i].mode    = m;
    vecs[i].a       = av;
    vecs[i].b       = bv;
    vecs[i].exp_p   = ep;
    vecs[i].exp_sat = es;
    vecs[i].exp_lat = el;
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    exp_acc   = 0;
    exp_apx   = 0;
    sel       = 0;
    rstN      = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    mode      = 1'b0;
    out_ready = 1'b1;

    set_vec(0,  0, 1'b0,     1000,   300,      1171, 1'b0, 4);
    set_vec(1,  0, 1'b1,     1000,   300,       768, 1'b0, 3);
    set_vec(2,  0, 1'b0,    -1000,   300,     -1172, 1'b0, 4);
    set_vec(3,  0, 1'b1,    -1000,   300,     -1024, 1'b0, 3);
    set_vec(4,  0, 1'b0,     1000,  -300,     -1172, 1'b0, 4);
    set_vec(5,  0, 1'b0,  8388607,  4095, 134184944, 1'b0, 4);
    set_vec(6,  1, 1'b0,     1000,   300,      1171, 1'b0, 4);
    set_vec(7,  1, 1'b0,  8388607,  4095,     32767, 1'b1, 4);
    set_vec(8,  1, 1'b0, -8388608,  4095,    -32768, 1'b1, 4);
    set_vec(9,  2, 1'b0,        2,     3,         6, 1'b0, 4);
    set_vec(10, 2, 1'b1,      300,     5,         0, 1'b0, 3);

    // Reset values while reset is held.
    #12;
    checkOutput("rst_p", cur_p, 0);
    checkOutput("rst_out_valid", longint'(cur_ov), 0);
    checkOutput("rst_busy", longint'(cur_busy), 0);
    checkOutput("rst_acc_cnt", longint'(cur_acc), 0);
    checkOutput("rst_apx_cnt", longint'(cur_apx), 0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("idle_in_ready", longint'(cur_ready), 1);

    // Table-driven vectors with out_ready tied high.
    foreach (vecs[i]) begin
      sel = vecs[i].sel;
      applyStimulus(vecs[i].mode, vecs[i].a, vecs[i].b, lat);
      if (vecs[i].mode) exp_apx++;
      else exp_acc++;
      checkOutput($sformatf("v%0d_latency", i), longint'(lat), longint'(vecs[i].exp_lat));
      checkOutput($sformatf("v%0d_p", i), cur_p, vecs[i].exp_p);
      checkOutput($sformatf("v%0d_sat", i), longint'(cur_sat), longint'(vecs[i].exp_sat));
      checkOutput($sformatf("v%0d_acc_cnt", i), longint'(cur_acc), longint'(exp_acc));
      checkOutput($sformatf("v%0d_apx_cnt", i), longint'(cur_apx), longint'(exp_apx));
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d_released", i), longint'(cur_ov), 0);
    end

    // Backpressure: result must hold while new operands wait in HOLD.
    sel       = 0;
    out_ready = 1'b0;
    applyStimulus(1'b0, 1000, 300, lat);
    exp_acc++;
    checkOutput("bp_latency", longint'(lat), 4);
    @(negedge clk);
    a        = 24'(-1000);
    b        = 13'd300;
    mode     = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("bp_hold%0d_p", k), cur_p, 1171);
      checkOutput($sformatf("bp_hold%0d_valid", k), longint'(cur_ov), 1);
      checkOutput($sformatf("bp_hold%0d_in_ready", k), longint'(cur_ready), 0);
    end
    checkOutput("bp_acc_cnt_held", longint'(cur_acc), longint'(exp_acc));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_release_valid", longint'(cur_ov), 0);
    checkOutput("bp_release_in_ready", longint'(cur_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("bp_new_accepted_busy", longint'(cur_busy), 1);
    lat = 1;
    while (!cur_ov && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    exp_acc++;
    checkOutput("bp_new_latency", longint'(lat), 4);
    checkOutput("bp_new_p", cur_p, -1172);
    checkOutput("bp_new_acc_cnt", longint'(cur_acc), longint'(exp_acc));
    @(posedge clk);
    #1;

    // Asynchronous reset while the operation sits in LO.
    @(negedge clk);
    a        = 24'd1000;
    b        = 13'd300;
    mode     = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("arst_p", cur_p, 0);
    checkOutput("arst_sat", longint'(cur_sat), 0);
    checkOutput("arst_valid", longint'(cur_ov), 0);
    checkOutput("arst_busy", longint'(cur_busy), 0);
    checkOutput("arst_acc_cnt", longint'(cur_acc), 0);
    @(negedge clk);
    rstN    = 1'b1;
    exp_acc = 0;
    exp_apx = 0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("arst_no_late_valid", longint'(cur_ov), 0);
    sel = 2;
    applyStimulus(1'b0, 2, 3, lat);
    exp_acc++;
    checkOutput("post_rst_latency", longint'(lat), 4);
    checkOutput("post_rst_p", cur_p, 6);
    checkOutput("post_rst_acc_cnt", longint'(cur_acc), longint'(exp_acc));
    checkOutput("post_rst_apx_cnt", longint'(cur_apx), 0);
    @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
